// File: rtl/axi_cmd_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ command requesters onto one downstream
// command/read channel, with one transaction outstanding at a time.
module axi_cmd_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic [NUM_REQ-1:0]                s_cmd_valid,
    output logic [NUM_REQ-1:0]                s_cmd_ready,
    input  logic [NUM_REQ-1:0]                s_cmd_write,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] s_cmd_addr,
    input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0] s_cmd_wdata,
    input  logic [NUM_REQ*AXI_STRB_WIDTH-1:0] s_cmd_wstrb,
    input  logic [NUM_REQ*8-1:0]              s_cmd_len,
    output logic [AXI_DATA_WIDTH-1:0]         s_rdata,
    output logic [NUM_REQ-1:0]                s_rvalid,
    input  logic [NUM_REQ-1:0]                s_rready,
    output logic [1:0]                        s_resp,
    output logic [NUM_REQ-1:0]                s_done,

    output logic                              m_cmd_valid,
    input  logic                              m_cmd_ready,
    output logic                              m_cmd_write,
    output logic [AXI_ADDR_WIDTH-1:0]         m_cmd_addr,
    output logic [AXI_DATA_WIDTH-1:0]         m_cmd_wdata,
    output logic [AXI_STRB_WIDTH-1:0]         m_cmd_wstrb,
    output logic [7:0]                        m_cmd_len,
    input  logic [AXI_DATA_WIDTH-1:0]         m_rdata,
    input  logic                              m_rvalid,
    output logic                              m_rready,
    input  logic [1:0]                        m_resp,
    input  logic                              m_done,

    output logic                              busy,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StBusy
    } state_e;

    state_e         state_q;
    logic [IdW-1:0] grant_q;
    logic [IdW-1:0] last_q;

    logic [IdW-1:0] winner;
    logic [IdW-1:0] cand;
    logic           found;
    logic           in_issue;
    logic           in_busy;
    logic           req_live;
    logic           cmd_hs;

    // Unpack the flattened request fields so the grant mux is a plain array read.
    logic [AXI_ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [AXI_DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [AXI_STRB_WIDTH-1:0] wstrb_arr [NUM_REQ];
    logic [7:0]                len_arr   [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = s_cmd_addr[g*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        assign wdata_arr[g] = s_cmd_wdata[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        assign wstrb_arr[g] = s_cmd_wstrb[g*AXI_STRB_WIDTH +: AXI_STRB_WIDTH];
        assign len_arr[g]   = s_cmd_len[g*8 +: 8];
    end

    // Search starts one past the last completed owner, wrapping at NUM_REQ.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        cand   = last_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (cand == IdW'(NUM_REQ - 1)) ? '0 : cand + IdW'(1);
            if (!found && s_cmd_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign in_issue = !rst && (state_q == StIssue);
    assign in_busy  = !rst && (state_q == StBusy);
    assign req_live = s_cmd_valid[grant_q];
    assign cmd_hs   = m_cmd_valid && m_cmd_ready;

    assign m_cmd_valid = in_issue && req_live;
    assign m_cmd_write = s_cmd_write[grant_q];
    assign m_cmd_addr  = addr_arr[grant_q];
    assign m_cmd_wdata = wdata_arr[grant_q];
    assign m_cmd_wstrb = wstrb_arr[grant_q];
    assign m_cmd_len   = len_arr[grant_q];

    assign m_rready = in_busy && s_rready[grant_q];
    assign s_rdata  = m_rdata;
    assign s_resp   = m_resp;
    assign busy     = !rst && (state_q != StIdle);
    assign grant_id = grant_q;

    always_comb begin
        s_cmd_ready = '0;
        s_rvalid    = '0;
        s_done      = '0;
        if (cmd_hs) begin
            s_cmd_ready[grant_q] = 1'b1;
        end
        if (in_busy) begin
            s_rvalid[grant_q] = m_rvalid;
            s_done[grant_q]   = m_done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= IdW'(NUM_REQ - 1);
        end else begin
            case (state_q)
                StIdle: begin
                    if (|s_cmd_valid) begin
                        grant_q <= winner;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    // A withdrawn request abandons the grant without touching priority.
                    if (!req_live) begin
                        state_q <= StIdle;
                    end else if (m_cmd_ready) begin
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (m_done) begin
                        last_q  <= grant_q;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_cmd_arbiter.sv
// Directed bench for axi_cmd_arbiter: reset, round-robin order, read bursts,
// withdrawn requests, reset mid-transaction and stray downstream activity.
module tb_axi_cmd_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    s_cmd_valid;
    logic [N-1:0]    s_cmd_ready;
    logic [N-1:0]    s_cmd_write;
    logic [N*AW-1:0] s_cmd_addr;
    logic [N*DW-1:0] s_cmd_wdata;
    logic [N*SW-1:0] s_cmd_wstrb;
    logic [N*8-1:0]  s_cmd_len;
    logic [DW-1:0]   s_rdata;
    logic [N-1:0]    s_rvalid;
    logic [N-1:0]    s_rready;
    logic [1:0]      s_resp;
    logic [N-1:0]    s_done;
    logic            m_cmd_valid;
    logic            m_cmd_ready;
    logic            m_cmd_write;
    logic [AW-1:0]   m_cmd_addr;
    logic [DW-1:0]   m_cmd_wdata;
    logic [SW-1:0]   m_cmd_wstrb;
    logic [7:0]      m_cmd_len;
    logic [DW-1:0]   m_rdata;
    logic            m_rvalid;
    logic            m_rready;
    logic [1:0]      m_resp;
    logic            m_done;
    logic            busy;
    logic [1:0]      grant_id;

    logic [AW-1:0] addr_v  [N];
    logic [DW-1:0] wdata_v [N];
    logic [SW-1:0] strb_v  [N];
    logic [7:0]    len_v   [N];

    int n_tests = 0;
    int n_fail  = 0;
    int beats;
    int seen;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign s_cmd_addr[g*AW +: AW]  = addr_v[g];
        assign s_cmd_wdata[g*DW +: DW] = wdata_v[g];
        assign s_cmd_wstrb[g*SW +: SW] = strb_v[g];
        assign s_cmd_len[g*8 +: 8]     = len_v[g];
    end

    axi_cmd_arbiter #(
        .NUM_REQ       (N),
        .AXI_ADDR_WIDTH(AW),
        .AXI_DATA_WIDTH(DW),
        .AXI_STRB_WIDTH(SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_cmd_valid(s_cmd_valid),
        .s_cmd_ready(s_cmd_ready),
        .s_cmd_write(s_cmd_write),
        .s_cmd_addr (s_cmd_addr),
        .s_cmd_wdata(s_cmd_wdata),
        .s_cmd_wstrb(s_cmd_wstrb),
        .s_cmd_len  (s_cmd_len),
        .s_rdata    (s_rdata),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .s_resp     (s_resp),
        .s_done     (s_done),
        .m_cmd_valid(m_cmd_valid),
        .m_cmd_ready(m_cmd_ready),
        .m_cmd_write(m_cmd_write),
        .m_cmd_addr (m_cmd_addr),
        .m_cmd_wdata(m_cmd_wdata),
        .m_cmd_wstrb(m_cmd_wstrb),
        .m_cmd_len  (m_cmd_len),
        .m_rdata    (m_rdata),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .m_resp     (m_resp),
        .m_done     (m_done),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        s_cmd_valid = '0;
        s_cmd_write = '0;
        s_rready    = '0;
        m_cmd_ready = 1'b0;
        m_rdata     = '0;
        m_rvalid    = 1'b0;
        m_resp      = 2'b00;
        m_done      = 1'b0;
        addr_v      = '{32'h0000_0040, 32'h0000_0080, 32'h0000_0100, 32'h0000_0200};
        wdata_v     = '{32'hDA7A_0000, 32'hDA7A_0001, 32'hDA7A_0002, 32'hDA7A_0003};
        strb_v      = '{4'h1, 4'h2, 4'h4, 4'h8};
        len_v       = '{8'd0, 8'd0, 8'd0, 8'd0};
        tick();
        tick();

        // Outputs must stay quiet under reset even with every input shouting.
        s_cmd_valid = 4'hF;
        m_done      = 1'b1;
        m_rvalid    = 1'b1;
        s_rready    = 4'hF;
        m_cmd_ready = 1'b1;
        settle();
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_m_cmd_valid", m_cmd_valid, 0);
        check("rst_s_cmd_ready", s_cmd_ready, 0);
        check("rst_s_rvalid", s_rvalid, 0);
        check("rst_s_done", s_done, 0);
        check("rst_m_rready", m_rready, 0);
        tick();
        s_cmd_valid = '0;
        m_done      = 1'b0;
        m_rvalid    = 1'b0;
        s_rready    = '0;
        m_cmd_ready = 1'b0;
        rst         = 1'b0;
        tick();

        // Single write from requester 2.
        s_cmd_valid = 4'b0100;
        s_cmd_write = 4'b0100;
        m_cmd_ready = 1'b1;
        m_resp      = 2'b01;
        settle();
        check("single_lat_idle", m_cmd_valid, 0);
        check("resp_pass", s_resp, 2'b01);
        tick();
        check("single_mvalid", m_cmd_valid, 1);
        check("single_addr", m_cmd_addr, 32'h100);
        check("single_write", m_cmd_write, 1);
        check("single_wdata", m_cmd_wdata, 32'hDA7A_0002);
        check("single_wstrb", m_cmd_wstrb, 4'h4);
        check("single_len", m_cmd_len, 0);
        check("single_grant", grant_id, 2);
        check("single_cready", s_cmd_ready, 4'b0100);
        check("single_busy", busy, 1);
        tick();
        s_cmd_valid = '0;
        settle();
        check("single_cready_once", s_cmd_ready, 0);
        check("single_mvalid_busy", m_cmd_valid, 0);
        m_done = 1'b1;
        settle();
        check("single_done", s_done, 4'b0100);
        tick();
        m_done = 1'b0;
        settle();
        check("single_done_once", s_done, 0);
        check("single_idle", busy, 0);

        // All four requesting continuously from reset: 0,1,2,3,0.
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        s_cmd_valid = 4'hF;
        s_cmd_write = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_grant", grant_id, k % 4);
            check("rr_cready", s_cmd_ready, 4'b0001 << (k % 4));
            tick();
            m_done = 1'b1;
            settle();
            check("rr_done", s_done, 4'b0001 << (k % 4));
            tick();
            m_done = 1'b0;
        end
        s_cmd_valid = '0;

        // Read burst of 4 beats for requester 2 with s_rready[2] toggling.
        s_cmd_valid = 4'b0100;
        len_v[2]    = 8'd3;
        settle();
        check("burst_pre_idle", busy, 0);
        tick();
        check("burst_grant", grant_id, 2);
        check("burst_len", m_cmd_len, 3);
        check("burst_write", m_cmd_write, 0);
        tick();
        s_cmd_valid = '0;
        beats       = 0;
        seen        = 0;
        for (int c = 0; c < 8; c++) begin
            s_rready = ((c % 2 == 0) ? 4'b0100 : 4'b0000) | 4'b1011;
            m_rvalid = (beats < 4);
            m_rdata  = 32'hBEEF_0000 + beats;
            settle();
            check("burst_rready", m_rready, (c % 2 == 0));
            check("burst_rvalid", s_rvalid, (beats < 4) ? 4'b0100 : 4'b0000);
            check("burst_rdata", s_rdata, 32'hBEEF_0000 + beats);
            if (s_rvalid[2] && m_rready) seen++;
            if (m_rvalid && (c % 2 == 0)) beats++;
            tick();
        end
        check("burst_beats", seen, 4);
        m_rvalid = 1'b0;
        s_rready = '0;
        m_done   = 1'b1;
        settle();
        check("burst_done", s_done, 4'b0100);
        tick();
        m_done = 1'b0;

        // Requester 1 withdraws while the downstream stalls; priority stays at 2.
        s_cmd_valid = 4'b0010;
        m_cmd_ready = 1'b0;
        tick();
        check("drop_grant", grant_id, 1);
        check("drop_mvalid", m_cmd_valid, 1);
        check("drop_cready_stall", s_cmd_ready, 0);
        s_cmd_valid = '0;
        settle();
        check("drop_mvalid_off", m_cmd_valid, 0);
        check("drop_cready", s_cmd_ready, 0);
        tick();
        check("drop_idle", busy, 0);
        s_cmd_valid = 4'b0110;
        m_cmd_ready = 1'b1;
        tick();
        check("drop_regrant", grant_id, 1);
        check("drop_regrant_cready", s_cmd_ready, 4'b0010);
        tick();
        s_cmd_valid = '0;
        m_done      = 1'b1;
        settle();
        check("drop_done", s_done, 4'b0010);
        tick();
        m_done = 1'b0;

        // Reset while requester 3 has a read in flight.
        s_cmd_valid = 4'b1000;
        tick();
        tick();
        s_cmd_valid = '0;
        m_rvalid    = 1'b1;
        s_rready    = 4'b1000;
        settle();
        check("rstb_rvalid", s_rvalid, 4'b1000);
        check("rstb_rready", m_rready, 1);
        rst    = 1'b1;
        m_done = 1'b1;
        settle();
        check("rstb_busy", busy, 0);
        check("rstb_done", s_done, 0);
        check("rstb_rvalid_off", s_rvalid, 0);
        check("rstb_rready_off", m_rready, 0);
        tick();
        rst = 1'b0;
        settle();
        check("rstb_after_busy", busy, 0);
        check("rstb_after_done", s_done, 0);
        m_done      = 1'b0;
        m_rvalid    = 1'b0;
        s_rready    = '0;
        s_cmd_valid = 4'b1001;
        tick();
        check("rstb_grant", grant_id, 0);
        check("rstb_cready", s_cmd_ready, 4'b0001);
        tick();
        s_cmd_valid = '0;
        m_done      = 1'b1;
        settle();
        check("rstb_done_new", s_done, 4'b0001);
        tick();
        m_done = 1'b0;

        // Stray downstream activity while idle.
        m_done   = 1'b1;
        m_rvalid = 1'b1;
        s_rready = 4'hF;
        settle();
        check("stray_done", s_done, 0);
        check("stray_rvalid", s_rvalid, 0);
        check("stray_rready", m_rready, 0);
        check("stray_mvalid", m_cmd_valid, 0);
        tick();
        check("stray_busy", busy, 0);
        check("stray_grant", grant_id, 0);
        m_done   = 1'b0;
        m_rvalid = 1'b0;
        s_rready = '0;

        // A lone requester is granted again right after its own completion.
        s_cmd_valid = 4'b0001;
        tick();
        check("lone_grant", grant_id, 0);
        check("lone_cready", s_cmd_ready, 4'b0001);
        tick();
        s_cmd_valid = '0;
        m_done      = 1'b1;
        settle();
        check("lone_done", s_done, 4'b0001);
        tick();
        m_done = 1'b0;
        settle();
        check("lone_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
